// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage for a single-cycle RISC-V core.
//               Holds the program counter and a word-addressed instruction
//               memory that is boot-loaded through a write port while idle.
//               It presents the instruction at pc (and its opcode field)
//               combinationally. Each cycle it then advances pc sequentially,
//               redirects it to a branch target, or halts on an all-zero
//               end-of-program word or on an address fault.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           : clock, all state updates on the rising edge
//   reset_i         : asynchronous active-high reset
//   start_i         : begin execution at RESET_PC (IDLE only)
//   load_en_i       : instruction memory write strobe (IDLE only)
//   load_addr_i     : word index of the write
//   load_data_i     : instruction word to write
//   stall_i         : hold pc and the retire counter this cycle
//   branch_taken_i  : redirect pc to branch_target_i at the next edge
//   branch_target_i : byte address of the redirect
//   pc_o            : current fetch byte address
//   instr_o         : fetched instruction (zero outside RUN)
//   opcode_o        : instr_o[6:0]
//   instr_valid_o   : instr_o is a live, non-zero instruction in RUN
//   halted_o        : unit is in HALT
//   fault_o         : sticky, HALT was entered on an address fault
//   instr_count_o   : instructions retired since the last reset
// ============================================================================
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         c_ADDR_W   = $clog2(IMEM_DEPTH)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                load_en_i,
    input  logic [c_ADDR_W-1:0] load_addr_i,
    input  logic [31:0]         load_data_i,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [31:0]         branch_target_i,
    output logic [31:0]         pc_o,
    output logic [31:0]         instr_o,
    output logic [6:0]          opcode_o,
    output logic                instr_valid_o,
    output logic                halted_o,
    output logic                fault_o,
    output logic [31:0]         instr_count_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // First byte address past the end of memory; widened so the compare
    // cannot overflow for any legal depth.
    localparam logic [32:0] c_BYTE_LIMIT = 33'(IMEM_DEPTH) << 2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;

    logic [31:0] imem_q [IMEM_DEPTH];

    logic [31:0] w_fetch_word;
    logic [31:0] w_cand;
    logic        w_cand_fault;

    // ------------------------------------------------------------------------
    // Instruction memory: written only while idle, never reset so that a
    // loaded program survives a reset and can be re-run.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && load_en_i) begin
            imem_q[load_addr_i] <= load_data_i;
        end
    end

    assign w_fetch_word = imem_q[pc_q[c_ADDR_W+1:2]];

    // Next-pc candidate and its legality: must be word aligned and inside
    // the instruction memory.
    assign w_cand       = branch_taken_i ? branch_target_i : (pc_q + 32'd4);
    assign w_cand_fault = (w_cand[1:0] != 2'b00) ||
                          ({1'b0, w_cand} >= c_BYTE_LIMIT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                if (stall_i) begin
                    // Instruction is re-presented; a pending branch will be
                    // seen again when the stall releases.
                end else if (w_fetch_word == 32'h0) begin
                    state_d = S_HALT;
                end else begin
                    // The current instruction retires even when its
                    // successor address faults.
                    count_d = count_q + 32'd1;
                    if (w_cand_fault) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = w_cand;
                    end
                end
            end
            S_HALT: begin
                // Absorbing; only reset leaves.
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        instr_o       = 32'h0;
        instr_valid_o = 1'b0;
        halted_o      = 1'b0;
        case (state_q)
            S_RUN: begin
                instr_o       = w_fetch_word;
                instr_valid_o = (w_fetch_word != 32'h0);
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign opcode_o      = instr_o[6:0];
    assign pc_o          = pc_q;
    assign fault_o       = fault_q;
    assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. A 256-word
//               instance covers boot, branch, stall, faults, load gating and
//               reset; a 4-word instance covers the end-of-memory fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_W0 = 32'h00A0_0093;
    localparam logic [31:0] c_W1 = 32'h0030_8133;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] pc, instr, instr_count;
    logic [6:0]  opcode;
    logic        instr_valid, halted, fault;

    logic [31:0] s_pc, s_instr, s_count;
    logic [6:0]  s_opcode;
    logic        s_valid, s_halted, s_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.IMEM_DEPTH(256), .RESET_PC(32'h0)) u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .stall_i(stall),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .pc_o(pc), .instr_o(instr), .opcode_o(opcode),
        .instr_valid_o(instr_valid), .halted_o(halted), .fault_o(fault),
        .instr_count_o(instr_count)
    );

    instr_fetch_unit #(.IMEM_DEPTH(4), .RESET_PC(32'h0)) u_small (
        .clk_i(clk), .reset_i(reset), .start_i(start), .load_en_i(load_en),
        .load_addr_i(load_addr[1:0]), .load_data_i(load_data), .stall_i(stall),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .pc_o(s_pc), .instr_o(s_instr), .opcode_o(s_opcode),
        .instr_valid_o(s_valid), .halted_o(s_halted), .fault_o(s_fault),
        .instr_count_o(s_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", instr_count); end
        checks++; if ({instr_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {instr_valid, halted, fault}); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    endtask

    task automatic test_boot();
        apply_reset();
        load_word(8'd0, c_W0);
        load_word(8'd1, c_W1);
        load_word(8'd2, 32'h0);
        pulse_start();
        checks++; if (pc !== 32'h0 || opcode !== 7'h13 || instr_valid !== 1'b1) begin errors++; $display("FAIL boot_c0 got pc %h op %h v %b exp pc 0 op 13 v 1", pc, opcode, instr_valid); end
        tick();
        checks++; if (pc !== 32'h4 || opcode !== 7'h33 || instr !== c_W1) begin errors++; $display("FAIL boot_c1 got pc %h instr %h exp pc 4 instr %h", pc, instr, c_W1); end
        tick();
        checks++; if (pc !== 32'h8 || opcode !== 7'h00 || instr_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL boot_c2 got pc %h op %h v %b h %b exp pc 8 op 0 v 0 h 0", pc, opcode, instr_valid, halted); end
        tick();
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL boot_halt got h %b f %b exp h 1 f 0", halted, fault); end
        checks++; if (instr_count !== 32'd2 || pc !== 32'h8) begin errors++; $display("FAIL boot_count got cnt %0d pc %h exp cnt 2 pc 8", instr_count, pc); end
    endtask

    task automatic test_branch();
        apply_reset();
        load_word(8'd4, 32'h0000_0013);
        load_word(8'd5, 32'h0);
        pulse_start();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h10;
        tick();
        branch_taken  = 1'b0;
        checks++; if (pc !== 32'h10 || instr_count !== 32'd2) begin errors++; $display("FAIL branch_redirect got pc %h cnt %0d exp pc 10 cnt 2", pc, instr_count); end
        checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL branch_opcode got %h exp 13", opcode); end
        tick();
        checks++; if (pc !== 32'h14 || instr_count !== 32'd3 || instr_valid !== 1'b0) begin errors++; $display("FAIL branch_seq got pc %h cnt %0d v %b exp pc 14 cnt 3 v 0", pc, instr_count, instr_valid); end
        tick();
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL branch_halt got h %b f %b exp h 1 f 0", halted, fault); end
    endtask

    task automatic test_stall_vs_branch();
        apply_reset();
        load_word(8'd2, c_W0);
        load_word(8'd8, c_W1);
        load_word(8'd9, 32'h0);
        pulse_start();
        tick();
        tick();
        checks++; if (pc !== 32'h8 || instr_count !== 32'd2) begin errors++; $display("FAIL stall_pre got pc %h cnt %0d exp pc 8 cnt 2", pc, instr_count); end
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h8 || instr_count !== 32'd2) begin errors++; $display("FAIL stall_hold_%0d got pc %h cnt %0d exp pc 8 cnt 2", i, pc, instr_count); end
        end
        stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'h20 || instr_count !== 32'd3 || opcode !== 7'h33) begin errors++; $display("FAIL stall_release got pc %h cnt %0d op %h exp pc 20 cnt 3 op 33", pc, instr_count, opcode); end
    endtask

    task automatic test_fault_misaligned();
        apply_reset();
        pulse_start();
        branch_taken  = 1'b1;
        branch_target = 32'h6;
        tick();
        branch_taken  = 1'b0;
        checks++; if (halted !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL misalign_flags got h %b f %b exp h 1 f 1", halted, fault); end
        checks++; if (pc !== 32'h0 || instr_count !== 32'd1 || instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_state got pc %h cnt %0d v %b exp pc 0 cnt 1 v 0", pc, instr_count, instr_valid); end
        // Everything is ignored in HALT, including a write to word 0.
        start = 1'b1; load_en = 1'b1; load_addr = 8'd0; load_data = 32'h0;
        branch_taken = 1'b1; branch_target = 32'h4;
        tick();
        tick();
        start = 1'b0; load_en = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 32'h0 || instr_count !== 32'd1 || halted !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL halt_absorb got pc %h cnt %0d h %b f %b exp pc 0 cnt 1 h 1 f 1", pc, instr_count, halted, fault); end
    endtask

    task automatic test_load_gating();
        apply_reset();
        load_word(8'd2, 32'h0);
        pulse_start();
        load_en = 1'b1; load_addr = 8'd1; load_data = 32'h1234_5677;
        tick();
        load_en = 1'b0;
        checks++; if (pc !== 32'h4 || instr !== c_W1) begin errors++; $display("FAIL load_run got pc %h instr %h exp pc 4 instr %h", pc, instr, c_W1); end
        tick();
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL load_halt got h %b exp 1", halted); end
        load_en = 1'b1; load_addr = 8'd0; load_data = 32'h0000_0077;
        tick();
        load_en = 1'b0;
        apply_reset();
        pulse_start();
        checks++; if (instr !== c_W0) begin errors++; $display("FAIL load_readback0 got %h exp %h", instr, c_W0); end
        tick();
        checks++; if (instr !== c_W1) begin errors++; $display("FAIL load_readback1 got %h exp %h", instr, c_W1); end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        load_word(8'd2, c_W0);
        load_word(8'd3, 32'h0);
        pulse_start();
        tick();
        tick();
        checks++; if (pc !== 32'h8 || instr_count !== 32'd2) begin errors++; $display("FAIL midrst_pre got pc %h cnt %0d exp pc 8 cnt 2", pc, instr_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || instr_count !== 32'd0) begin errors++; $display("FAIL midrst_regs got pc %h cnt %0d exp pc 0 cnt 0", pc, instr_count); end
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL midrst_idle got v %b instr %h h %b exp v 0 instr 0 h 0", instr_valid, instr, halted); end
        #1;
        reset = 1'b0;
        pulse_start();
        checks++; if (pc !== 32'h0 || instr !== c_W0) begin errors++; $display("FAIL replay_c0 got pc %h instr %h exp pc 0 instr %h", pc, instr, c_W0); end
        tick();
        tick();
        checks++; if (pc !== 32'h8 || instr !== c_W0) begin errors++; $display("FAIL replay_c2 got pc %h instr %h exp pc 8 instr %h", pc, instr, c_W0); end
        tick();
        tick();
        checks++; if (halted !== 1'b1 || instr_count !== 32'd3 || pc !== 32'hC) begin errors++; $display("FAIL replay_end got h %b cnt %0d pc %h exp h 1 cnt 3 pc c", halted, instr_count, pc); end
    endtask

    task automatic test_end_of_memory();
        apply_reset();
        load_word(8'd0, c_W0);
        load_word(8'd1, c_W1);
        load_word(8'd2, c_W0);
        load_word(8'd3, c_W1);
        pulse_start();
        checks++; if (s_pc !== 32'h0 || s_valid !== 1'b1) begin errors++; $display("FAIL eom_c0 got pc %h v %b exp pc 0 v 1", s_pc, s_valid); end
        tick();
        tick();
        tick();
        checks++; if (s_pc !== 32'hC || s_opcode !== 7'h33 || s_instr !== c_W1) begin errors++; $display("FAIL eom_last got pc %h op %h exp pc c op 33", s_pc, s_opcode); end
        tick();
        checks++; if (s_halted !== 1'b1 || s_fault !== 1'b1) begin errors++; $display("FAIL eom_flags got h %b f %b exp h 1 f 1", s_halted, s_fault); end
        checks++; if (s_pc !== 32'hC || s_count !== 32'd4) begin errors++; $display("FAIL eom_state got pc %h cnt %0d exp pc c cnt 4", s_pc, s_count); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = 8'd0;
        load_data = 32'h0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0;
        #2;
        test_reset();
        test_boot();
        test_branch();
        test_stall_vs_branch();
        test_fault_misaligned();
        test_load_gating();
        test_reset_mid_run();
        test_end_of_memory();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
